// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner: walks an active-low column, synchronizes and debounces
// the active-low rows, and reports one registered pulse plus a key code per press.
module keypad_scan #(
   parameter int unsigned SCAN_OVERFLOW  = 65535,
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] row_n_i,
   output logic [3:0] col_drive_o,
   output logic [3:0] key_code_o,
   output logic       key_valid_o,
   output logic       key_held_o
);

   localparam int unsigned TW = $clog2(SCAN_OVERFLOW + 1);
   localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 2);
   localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_OVERFLOW);
   localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_TICKS);
   localparam bit            DB_ONE   = (DEBOUNCE_TICKS == 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
   logic [1:0]    col_q, col_d;
   logic [1:0]    row_q, row_d;
   logic [3:0]    col_drive_q, col_drive_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;
   logic [3:0]    sync1_q, rows_q;
   logic          tick_s, hit_s, accept_s, release_s;
   logic [1:0]    hit_row_s;

   // two-flop synchronizer for the asynchronous row inputs
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 4'b1111;
         rows_q  <= 4'b1111;
      end else begin
         sync1_q <= row_n_i;
         rows_q  <= sync1_q;
      end
   end

   assign tick_s    = (tick_q == TICK_MAX);
   assign tick_d    = tick_s ? '0 : tick_q + TW'(1);
   assign cnt_inc_s = cnt_q + CW'(1);

   // lowest-index low row wins when several rows are pulled down
   always_comb begin
      hit_s     = 1'b1;
      hit_row_s = 2'd0;
      casez (rows_q)
         4'b???0: hit_row_s = 2'd0;
         4'b??01: hit_row_s = 2'd1;
         4'b?011: hit_row_s = 2'd2;
         4'b0111: hit_row_s = 2'd3;
         default: hit_s     = 1'b0;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= SCAN;
         tick_q      <= '0;
         cnt_q       <= '0;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         col_drive_q <= 4'b1110;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         col_drive_q <= col_drive_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   // next-state logic; the column only moves when no key owns the scanner
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      col_d     = col_q;
      accept_s  = 1'b0;
      release_s = 1'b0;
      if (tick_s) begin
         case (state_q)
            SCAN: begin
               if (hit_s) begin
                  row_d = hit_row_s;
                  cnt_d = CW'(1);
                  if (DB_ONE) begin
                     accept_s = 1'b1;
                     state_d  = HELD;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (hit_s && (hit_row_s == row_q)) begin
                  cnt_d = cnt_inc_s;
                  if (cnt_inc_s >= DB_MAX) begin
                     accept_s = 1'b1;
                     state_d  = HELD;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end else begin
                  state_d = SCAN;
                  col_d   = col_q + 2'd1;
               end
            end
            HELD: begin
               if (rows_q[row_q]) begin
                  cnt_d   = CW'(1);
                  state_d = RELEASE;
               end else begin
                  state_d = HELD;
               end
            end
            RELEASE: begin
               if (rows_q[row_q]) begin
                  cnt_d = cnt_inc_s;
                  if (cnt_inc_s >= DB_MAX) begin
                     release_s = 1'b1;
                     state_d   = SCAN;
                     col_d     = col_q + 2'd1;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: state_d = SCAN;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // next values of the registered outputs
   always_comb begin
      col_drive_d = ~(4'b0001 << col_d);
      key_valid_d = accept_s;
      if (accept_s) begin
         key_code_d = {row_d, col_q};
         key_held_d = 1'b1;
      end else if (release_s) begin
         key_code_d = key_code_q;
         key_held_d = 1'b0;
      end else begin
         key_code_d = key_code_q;
         key_held_d = key_held_q;
      end
   end

   assign col_drive_o = col_drive_q;
   assign key_code_o  = key_code_q;
   assign key_valid_o = key_valid_q;
   assign key_held_o  = key_held_q;

endmodule
